mac_result_collector: RTL
=========================

Name: mac_result_collector

Overview:
- Downstream stage of the registered multiply-add pipeline (DATA_OUT = A*B + C, 3-cycle latency).
- Issue-side valid strobe travels through a delay line aligned to the MAC latency. Aligned results are captured into a first-word-fall-through FIFO.
- FIFO drains through a valid/ready handshake; overflow is flagged as sticky.
- Optional running accumulator of all aligned results.

Parameters:
- OUT_WIDTH, 16, width of MAC result and FIFO data (matches OUT_WIDTH of the MAC stage)
- LATENCY, 3, MAC pipeline depth in clocks; length of the valid delay line
- DEPTH, 8, FIFO entries (power of two, >= 2)
- ACC_WIDTH, 24, accumulator width (>= OUT_WIDTH)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- issue_valid  in  1  high in the same cycle A/B/C are presented to the MAC stage
- data_in  in  OUT_WIDTH  MAC DATA_OUT
- out_data  out  OUT_WIDTH  FIFO head entry
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts out_data this cycle
- count  out  $clog2(DEPTH+1)  current FIFO occupancy
- overflow  out  1  sticky: an aligned result was dropped because FIFO was full
- acc_clear  in  1  synchronous accumulator clear (only used with ACCUM_EN)
- acc_out  out  ACC_WIDTH  running sum

Behaviour:
- Reset (async assert, sync release via clk edge):
  - Valid delay line is cleared, so in-flight results are discarded.
  - Pointers and count are cleared, so out_valid=0 and count=0.
  - overflow=0, acc_out=0.
  - out_data is don't-care while out_valid=0.
- Delay line: vld[0] <= issue_valid; vld[i] <= vld[i-1]; aligned_valid = vld[LATENCY-1].
- Alignment: issue_valid sampled at edge t puts aligned_valid high in the cycle after edge t+LATENCY-1. In that cycle data_in holds the matching result.
- Write: when aligned_valid=1, data_in is written at the next edge if count<DEPTH or a read occurs in the same cycle.
- Drop: when aligned_valid=1, count==DEPTH and no read, the data is dropped and overflow<=1. overflow is cleared only by reset.
- Read: when out_valid && out_ready, the head pops at the edge. out_ready while empty has no effect.
- Simultaneous read+write: count unchanged, including at full and at count==1 (new data becomes head after the pop).
- FWFT: out_data = mem[rd_ptr], combinational from storage. out_valid = (count!=0), registered-state derived.
- Latency: an issue at edge t gives out_valid=1 after edge t+LATENCY (empty FIFO).
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH, never wraps.
- No back-pressure toward the MAC: it has no stall, so the drop policy above is mandatory.

Optional Feature:
- Macro: MAC_COLLECT_ACCUM_EN
- Defined:
  - On every aligned_valid, acc <= acc + zero-extended data_in, wrapping modulo 2^ACC_WIDTH. Dropped results are still summed.
  - acc_clear=1 alone: acc <= 0.
  - acc_clear and aligned_valid in the same cycle: acc <= zero-extended data_in.
  - acc_out = acc (registered).
- Undefined: accumulator logic is absent; acc_out is tied to 0 and acc_clear is ignored.

Test Plan:
- Single issue A=3,B=4,C=5, out_ready=0 -> out_valid rises after edge t+3, out_data=17, count=1; then out_ready=1 for one cycle -> count=0, out_valid=0.
- Four back-to-back issues (1*1+0, 2*2+1, 3*3+2, 4*4+3), out_ready=0 -> count=4; draining yields 1, 5, 11, 19 in order.
- DEPTH=8, out_ready=0, 10 consecutive issues with results 1..10 -> count=8, overflow=1, drain yields 1..8; overflow stays 1 until reset.
- FIFO full (8 entries) with out_ready=1 and aligned_valid in the same cycle -> count stays 8, overflow stays 0, head advances, new value appears last.
- Two issues, then reset pulsed one cycle before their aligned_valid -> after release, no entries appear, count=0, overflow=0.
- With MAC_COLLECT_ACCUM_EN: results 100, 200, 300 -> acc_out=600; acc_clear together with result 7 -> acc_out=7. Without the macro, acc_out=0 throughout.

Source files
------------

// File: rtl/mac_result_collector.sv
// Collects results from the 3-stage multiply-add pipeline into a FWFT FIFO with sticky overflow.
// Optional running accumulator of aligned results enabled by defining MAC_COLLECT_ACCUM_EN.
module mac_result_collector #(
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned LATENCY   = 3,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ACC_WIDTH = 24
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       issue_valid,
    input  logic [OUT_WIDTH-1:0]       data_in,
    output logic [OUT_WIDTH-1:0]       out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    input  logic                       acc_clear,
    output logic [ACC_WIDTH-1:0]       acc_out
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [LATENCY-1:0]   vld;
    logic                 aligned_valid_c;
    logic                 rd_en_c;
    logic                 wr_en_c;
    logic                 drop_c;
    logic [CNT_W-1:0]     count_nxt_c;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [OUT_WIDTH-1:0] mem [DEPTH];

    // Valid delay line matching the MAC pipeline depth
    generate
        if (LATENCY == 1) begin : g_vld_one
            always_ff @(posedge clk or posedge reset) begin
                if (reset) vld <= '0;
                else       vld <= issue_valid;
            end
        end else begin : g_vld_shift
            always_ff @(posedge clk or posedge reset) begin
                if (reset) vld <= '0;
                else       vld <= {vld[LATENCY-2:0], issue_valid};
            end
        end
    endgenerate

    assign aligned_valid_c = vld[LATENCY-1];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write when read
    always_comb begin
        rd_en_c     = out_valid & out_ready;
        wr_en_c     = aligned_valid_c & ((count != CNT_W'(DEPTH)) | rd_en_c);
        drop_c      = aligned_valid_c & (count == CNT_W'(DEPTH)) & ~rd_en_c;
        count_nxt_c = count;
        if (wr_en_c && !rd_en_c)      count_nxt_c = count + CNT_W'(1);
        else if (rd_en_c && !wr_en_c) count_nxt_c = count - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (wr_en_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en_c) rd_ptr <= rd_ptr + PTR_W'(1);
            count     <= count_nxt_c;
            out_valid <= (count_nxt_c != '0);
            if (drop_c) overflow <= 1'b1;
        end
    end

    // Storage carries no reset; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (wr_en_c) mem[wr_ptr] <= data_in;
    end

    assign out_data = mem[rd_ptr];

`ifdef MAC_COLLECT_ACCUM_EN
    logic [ACC_WIDTH-1:0] acc;

    // Dropped results are still summed; clear with a concurrent result restarts from that result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (acc_clear && aligned_valid_c) begin
            acc <= ACC_WIDTH'(data_in);
        end else if (acc_clear) begin
            acc <= '0;
        end else if (aligned_valid_c) begin
            acc <= acc + ACC_WIDTH'(data_in);
        end
    end

    assign acc_out = acc;
`else
    logic acc_clear_unused;

    assign acc_clear_unused = acc_clear;
    assign acc_out          = '0;
`endif

endmodule
